// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH   = 32;
   localparam int unsigned DEFAULT_MEMORY_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic PORT_CPU    = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a tie goes to the port that did not win last.
module rr_arbiter2
   import dmem_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_idx
);

   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = PORT_CPU;
      if (req0 && req1) begin
         grant_idx = ~last_grant;
      end else if (req1) begin
         grant_idx = PORT_LOADER;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port data memory.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int unsigned MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req0,
   input  logic                    we0,
   input  logic [MEMORY_DEPTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0]   wdata0,
   output logic                    ack0,
   output logic [DATA_WIDTH-1:0]   rdata0,
   output logic                    err0,
   input  logic                    req1,
   input  logic                    we1,
   input  logic [MEMORY_DEPTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0]   wdata1,
   output logic                    ack1,
   output logic [DATA_WIDTH-1:0]   rdata1,
   output logic                    err1,
   output logic                    mem_write,
   output logic                    mem_read,
   output logic [MEMORY_DEPTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_write_data,
   input  logic [DATA_WIDTH-1:0]   mem_read_data
);

   state_t                  state, next_state;
   logic                    owner, last_grant;
   logic                    we_q, oor_q;
   logic [MEMORY_DEPTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    grant_valid, grant_idx;
   logic                    latch;
   logic [MEMORY_DEPTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]   rd_word;

   rr_arbiter2 u_rr (
      .req0        (req0),
      .req1        (req1),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign sel_addr = grant_idx ? addr1 : addr0;
   assign rd_word  = (!we_q && !oor_q) ? mem_read_data : '0;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Memory strobes are only live in SERVE; a write is killed by a same-cycle reset.
   always_comb begin
      next_state     = state;
      latch          = 1'b0;
      ack0           = 1'b0;
      ack1           = 1'b0;
      mem_write      = 1'b0;
      mem_read       = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               next_state = SERVE;
               latch      = 1'b1;
            end
         end
         SERVE: begin
            next_state     = RESP;
            mem_address    = addr_q;
            mem_write      = we_q & ~oor_q & ~reset;
            mem_read       = ~we_q & ~oor_q;
            mem_write_data = wdata_q;
         end
         RESP: begin
            next_state = IDLE;
            ack0       = (owner == PORT_CPU);
            ack1       = (owner == PORT_LOADER);
         end
         default: next_state = IDLE;
      endcase
   end

   // Request latch on grant, response capture at the end of SERVE.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner      <= PORT_CPU;
         last_grant <= PORT_LOADER;
         we_q       <= 1'b0;
         oor_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata0     <= '0;
         rdata1     <= '0;
         err0       <= 1'b0;
         err1       <= 1'b0;
      end else begin
         if (latch) begin
            owner   <= grant_idx;
            we_q    <= grant_idx ? we1 : we0;
            addr_q  <= sel_addr;
            wdata_q <= grant_idx ? wdata1 : wdata0;
            oor_q   <= (sel_addr >= MEMORY_DEPTH'(MEMORY_DEPTH));
         end
         if (state == SERVE) begin
            last_grant <= owner;
            if (owner == PORT_CPU) begin
               rdata0 <= rd_word;
               err0   <= oor_q;
            end else begin
               rdata1 <= rd_word;
               err1   <= oor_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 8-word memory.
module tb_dmem_arbiter;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [7:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_write, mem_read;
   logic [7:0]  mem_address;
   logic [31:0] mem_write_data, mem_read_data;

   logic [31:0] mem     [8];
   logic [31:0] exp_mem [8];
   logic        mem_clear;
   exp_t        q [$];
   int          ntests = 0;
   int          nfail  = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .req0           (req0),
      .we0            (we0),
      .addr0          (addr0),
      .wdata0         (wdata0),
      .ack0           (ack0),
      .rdata0         (rdata0),
      .err0           (err0),
      .req1           (req1),
      .we1            (we1),
      .addr1          (addr1),
      .wdata1         (wdata1),
      .ack1           (ack1),
      .rdata1         (rdata1),
      .err1           (err1),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 8; i++) mem[i] <= 32'd0;
      end else if (mem_write && mem_address < 8'd8) begin
         mem[mem_address[2:0]] <= mem_write_data;
      end
   end
   assign mem_read_data = (mem_read && mem_address < 8'd8) ? mem[mem_address[2:0]] : 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic port, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.port  = port;
      e.rdata = rdata;
      e.err   = err;
      q.push_back(e);
   endtask

   task automatic check_mem(input string name);
      for (int i = 0; i < 8; i++) check(name, mem[i], exp_mem[i]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One complete access on a single port, with the SERVE-cycle memory strobes checked.
   task automatic do_access(input logic port, input logic we, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic exp_err);
      logic in_range;
      in_range = (addr < 8'd8);
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end
      push(port, exp_rdata, exp_err);
      tick();
      @(negedge clk);
      check("serve_mem_write", 32'(mem_write), 32'(we && in_range));
      check("serve_mem_read", 32'(mem_read), 32'(!we && in_range));
      check("serve_mem_address", 32'(mem_address), 32'(addr));
      tick();
      if (port) req1 = 1'b0;
      else      req0 = 1'b0;
      @(negedge clk);
      check("resp_ack", 32'(port ? ack1 : ack0), 32'd1);
      tick();
      if (we && in_range) exp_mem[addr[2:0]] = wdata;
   endtask

   // Scoreboard monitor: every ack pops one expected response.
   always @(negedge clk) begin
      if (ack0 || ack1) begin
         exp_t e;
         check("ack_overlap", 32'(ack0 & ack1), 32'd0);
         if (q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("sb_port", 32'(ack1), 32'(e.port));
            check("sb_rdata", ack1 ? rdata1 : rdata0, e.rdata);
            check("sb_err", 32'(ack1 ? err1 : err0), 32'(e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; mem_clear = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = 8'd0; wdata0 = 32'd0;
      req1 = 1'b0; we1 = 1'b0; addr1 = 8'd0; wdata1 = 32'd0;
      for (int i = 0; i < 8; i++) exp_mem[i] = 32'd0;
      tick();
      tick();
      mem_clear = 1'b0;
      reset     = 1'b0;

      @(negedge clk);
      check("rst_ack0", 32'(ack0), 32'd0);
      check("rst_ack1", 32'(ack1), 32'd0);
      check("rst_err0", 32'(err0), 32'd0);
      check("rst_err1", 32'(err1), 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_address", 32'(mem_address), 32'd0);

      // Write then read back on port 0
      do_access(1'b0, 1'b1, 8'd3, 32'hDEADBEEF, 32'd0, 1'b0);
      check_mem("mem_after_write3");
      do_access(1'b0, 1'b0, 8'd3, 32'd0, 32'hDEADBEEF, 1'b0);
      check("rdata1_untouched", rdata1, 32'd0);
      do_access(1'b1, 1'b1, 8'd1, 32'hA5A50001, 32'd0, 1'b0);
      check_mem("mem_after_write1");

      // Fairness: both ports request continuously from the same cycle
      do_reset();
      push(1'b0, 32'hDEADBEEF, 1'b0);
      push(1'b1, 32'hA5A50001, 1'b0);
      push(1'b0, 32'hDEADBEEF, 1'b0);
      push(1'b1, 32'hA5A50001, 1'b0);
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'd3;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'd1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         @(negedge clk);
         check("rr_ack0", 32'(ack0), 32'((k == 2) || (k == 8)));
         check("rr_ack1", 32'(ack1), 32'((k == 5) || (k == 11)));
         if (k == 11) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      tick();

      // Out-of-range addresses
      do_access(1'b1, 1'b1, 8'd8, 32'h12345678, 32'd0, 1'b1);
      check_mem("mem_after_oor_write");
      do_access(1'b0, 1'b0, 8'd200, 32'd0, 32'd0, 1'b1);

      // Reset during SERVE of a write
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 32'hBAD0BAD0;
      tick();
      reset = 1'b1;
      req0  = 1'b0;
      @(negedge clk);
      check("rst_serve_mem_write", 32'(mem_write), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ack0", 32'(ack0), 32'd0);
      check("post_rst_ack1", 32'(ack1), 32'd0);
      check_mem("mem_after_rst_write");

      // Port 0 wins the first tie after reset
      push(1'b0, 32'hDEADBEEF, 1'b0);
      push(1'b1, 32'hA5A50001, 1'b0);
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'd3;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'd1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         @(negedge clk);
         if (k == 2) begin
            check("tie_ack0_first", 32'(ack0), 32'd1);
            req0 = 1'b0;
         end
         if (k == 5) begin
            check("tie_ack1_second", 32'(ack1), 32'd1);
            req1 = 1'b0;
         end
      end
      tick();

      // Request dropped and address changed after the latch
      push(1'b0, 32'd0, 1'b0);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'd6; wdata0 = 32'hCAFEF00D;
      tick();
      req0 = 1'b0; addr0 = 8'd2; wdata0 = 32'h0BADF00D;
      @(negedge clk);
      check("latched_address", 32'(mem_address), 32'd6);
      check("latched_wdata", mem_write_data, 32'hCAFEF00D);
      tick();
      @(negedge clk);
      check("dropped_req_ack0", 32'(ack0), 32'd1);
      tick();
      exp_mem[6] = 32'hCAFEF00D;
      check_mem("mem_after_latched_write");

      tick();
      check("sb_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
